// File: rtl/cpu_pkg.sv
// cpu_pkg: shared core constants for the register file and its scoreboard.
package cpu_pkg;
   localparam int XLEN     = 32;
   localparam int AW       = 5;
   localparam int NREG     = 1 << AW;
   localparam int PORT_W   = 16;
   localparam int ZERO     = 0;
   localparam int PORT_REG = 31;
endpackage

// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: decode/writeback bus of the register file; master is the pipeline.
interface reg_file_sb_if #(
   parameter int XLEN   = cpu_pkg::XLEN,
   parameter int AW     = cpu_pkg::AW,
   parameter int NREG   = cpu_pkg::NREG,
   parameter int PORT_W = cpu_pkg::PORT_W
);
   logic [AW-1:0]   rs1In, rs2In, rdIn, issueRdIn;
   logic            useRs1In, useRs2In, WriteIn, issueIn;
   logic [XLEN-1:0] DataIn, Data1Out, Data2Out;
   logic            stallOut;
   logic [NREG-1:0] busyOut;
   logic [PORT_W-1:0] portOut;
   modport master(
      output rs1In, rs2In, useRs1In, useRs2In, rdIn, DataIn, WriteIn, issueIn, issueRdIn,
      input  Data1Out, Data2Out, stallOut, busyOut, portOut
   );
   modport slave(
      input  rs1In, rs2In, useRs1In, useRs2In, rdIn, DataIn, WriteIn, issueIn, issueRdIn,
      output Data1Out, Data2Out, stallOut, busyOut, portOut
   );
endinterface

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending bits set at issue, cleared at writeback,
// and the stall raised while a used source is still pending.
module reg_scoreboard #(
   parameter int NREG   = cpu_pkg::NREG,
   parameter int AW     = cpu_pkg::AW,
   parameter bit BYPASS = 1'b1
) (
   input  logic            clkIn,
   input  logic            resetIn,
   input  logic [AW-1:0]   rs1In,
   input  logic [AW-1:0]   rs2In,
   input  logic            useRs1In,
   input  logic            useRs2In,
   input  logic [AW-1:0]   rdIn,
   input  logic            WriteIn,
   input  logic            issueIn,
   input  logic [AW-1:0]   issueRdIn,
   output logic            stallOut,
   output logic [NREG-1:0] busyOut
);
   import cpu_pkg::*;
   logic [NREG-1:0] busy, busyNext;
   logic wrEn, pend1, pend2;
   assign wrEn = WriteIn && rdIn != AW'(ZERO);
   // set is applied last so a fresh issue supersedes a completing writeback
   always_comb begin
      busyNext = busy;
      if (wrEn) busyNext[rdIn] = 1'b0;
      if (issueIn && issueRdIn != AW'(ZERO)) busyNext[issueRdIn] = 1'b1;
   end
   always_ff @(posedge clkIn or negedge resetIn)
      if (!resetIn) busy <= '0;
      else busy <= busyNext;
   assign pend1 = useRs1In && rs1In != AW'(ZERO) && busy[rs1In] && !(BYPASS && wrEn && rdIn == rs1In);
   assign pend2 = useRs2In && rs2In != AW'(ZERO) && busy[rs2In] && !(BYPASS && wrEn && rdIn == rs2In);
   assign stallOut = pend1 || pend2;
   assign busyOut = busy;
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: 2-read/1-write register file with x0 hardwired to zero, optional
// write-to-read bypass, registered display port and a busy scoreboard.
module reg_file_sb #(
   parameter int XLEN     = cpu_pkg::XLEN,
   parameter int NREG     = cpu_pkg::NREG,
   parameter int AW       = cpu_pkg::AW,
   parameter int PORT_W   = cpu_pkg::PORT_W,
   parameter int PORT_REG = cpu_pkg::PORT_REG,
   parameter bit BYPASS   = 1'b1
) (
   input logic clkIn,
   input logic resetIn,
   reg_file_sb_if.slave bus
);
   import cpu_pkg::*;
   logic [XLEN-1:0] regs [NREG];
   logic wrEn;
   assign wrEn = bus.WriteIn && bus.rdIn != AW'(ZERO);
   assign bus.Data1Out = bus.rs1In == AW'(ZERO) ? '0 :
                         (BYPASS && wrEn && bus.rdIn == bus.rs1In) ? bus.DataIn : regs[bus.rs1In];
   assign bus.Data2Out = bus.rs2In == AW'(ZERO) ? '0 :
                         (BYPASS && wrEn && bus.rdIn == bus.rs2In) ? bus.DataIn : regs[bus.rs2In];
   // wrEn already excludes x0, so a PORT_REG of 0 never updates the display
   always_ff @(posedge clkIn or negedge resetIn)
      if (!resetIn) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
         bus.portOut <= '0;
      end else begin
         if (wrEn) regs[bus.rdIn] <= bus.DataIn;
         if (wrEn && bus.rdIn == AW'(PORT_REG)) bus.portOut <= bus.DataIn[PORT_W-1:0];
      end
   reg_scoreboard #(.NREG(NREG), .AW(AW), .BYPASS(BYPASS)) scoreboard (
      .clkIn(clkIn),
      .resetIn(resetIn),
      .rs1In(bus.rs1In),
      .rs2In(bus.rs2In),
      .useRs1In(bus.useRs1In),
      .useRs2In(bus.useRs2In),
      .rdIn(bus.rdIn),
      .WriteIn(bus.WriteIn),
      .issueIn(bus.issueIn),
      .issueRdIn(bus.issueRdIn),
      .stallOut(bus.stallOut),
      .busyOut(bus.busyOut)
   );
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: drives a bypassing and a non-bypassing register file with the
// same stimulus and checks both against an array model every cycle.
module tb_reg_file_sb;
   logic clkIn = 1'b0;
   logic resetIn;
   logic [4:0] rs1, rs2, rd, issRd;
   logic u1, u2, we, iss;
   logic [31:0] din;
   int nCmp = 0, nBad = 0;
   bit chk = 0;

   reg_file_sb_if bus();
   reg_file_sb_if bus0();
   assign {bus.rs1In, bus.rs2In, bus.rdIn, bus.issueRdIn} = {rs1, rs2, rd, issRd};
   assign {bus.useRs1In, bus.useRs2In, bus.WriteIn, bus.issueIn, bus.DataIn} = {u1, u2, we, iss, din};
   assign {bus0.rs1In, bus0.rs2In, bus0.rdIn, bus0.issueRdIn} = {rs1, rs2, rd, issRd};
   assign {bus0.useRs1In, bus0.useRs2In, bus0.WriteIn, bus0.issueIn, bus0.DataIn} = {u1, u2, we, iss, din};

   reg_file_sb dut (.clkIn(clkIn), .resetIn(resetIn), .bus(bus));
   reg_file_sb #(.BYPASS(1'b0)) dut0 (.clkIn(clkIn), .resetIn(resetIn), .bus(bus0));

   always #5 clkIn = ~clkIn;

   // architectural model: register contents, pending set, display value
   logic [31:0] mReg [32];
   bit mBusy [32];
   logic [15:0] mPort;
   always @(posedge clkIn or negedge resetIn)
      if (!resetIn) begin
         for (int i = 0; i < 32; i++) begin
            mReg[i] <= 0;
            mBusy[i] <= 0;
         end
         mPort <= 0;
      end else begin
         if (we && rd != 0) begin
            mReg[rd] <= din;
            mBusy[rd] <= 0;
            if (rd == 31) mPort <= din[15:0];
         end
         if (iss && issRd != 0) mBusy[issRd] <= 1;
      end

   function automatic logic [31:0] expRead(logic [4:0] rs, bit byp);
      if (rs == 0) return 0;
      if (byp && we && rd == rs) return din;
      return mReg[rs];
   endfunction

   function automatic logic [31:0] expStall(bit byp);
      bit s1, s2;
      s1 = u1 && rs1 != 0 && mBusy[rs1] && !(byp && we && rd == rs1);
      s2 = u2 && rs2 != 0 && mBusy[rs2] && !(byp && we && rd == rs2);
      return {31'b0, s1 | s2};
   endfunction

   function automatic logic [31:0] expBusy();
      logic [31:0] v;
      for (int i = 0; i < 32; i++) v[i] = mBusy[i];
      return v;
   endfunction

   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      nCmp++;
      if (act !== exp) begin
         nBad++;
         $display("FAIL %s at %0t: got %h, want %h", nm, $time, act, exp);
      end
   endtask

   always @(negedge clkIn)
      if (chk) begin
         check("d1", bus.Data1Out, expRead(rs1, 1));
         check("d2", bus.Data2Out, expRead(rs2, 1));
         check("stall", {31'b0, bus.stallOut}, expStall(1));
         check("busy", bus.busyOut, expBusy());
         check("port", {16'b0, bus.portOut}, {16'b0, mPort});
         check("nb_d1", bus0.Data1Out, expRead(rs1, 0));
         check("nb_d2", bus0.Data2Out, expRead(rs2, 0));
         check("nb_stall", {31'b0, bus0.stallOut}, expStall(0));
         check("nb_busy", bus0.busyOut, expBusy());
      end

   task automatic idle();
      {rs1, rs2, rd, issRd, u1, u2, we, iss, din} = '0;
   endtask

   task automatic tick();
      @(posedge clkIn);
      #1;
   endtask

   initial begin
      resetIn = 1'b0;
      idle();
      tick();
      tick();
      chk = 1;
      rs1 = 5;
      #1 check("rst_d1", bus.Data1Out, 0);
      check("rst_busy", bus.busyOut, 0);
      check("rst_port", {16'b0, bus.portOut}, 0);
      tick();
      resetIn = 1'b1;
      // write x5, issue x12, then pulse reset mid-cycle
      we = 1; rd = 5; din = 32'hDEADBEEF; iss = 1; issRd = 12;
      tick();
      idle();
      rs1 = 5;
      #1 check("wr_x5", bus.Data1Out, 32'hDEADBEEF);
      check("busy_x12", bus.busyOut, 32'h0000_1000);
      #1 resetIn = 1'b0;
      #1 check("async_d1", bus.Data1Out, 0);
      check("async_busy", bus.busyOut, 0);
      tick();
      resetIn = 1'b1;
      // x0 write discarded, x0 issue ignored
      we = 1; rd = 0; din = 32'h12345678; iss = 1; issRd = 0;
      tick();
      idle();
      #1 check("x0_d2", bus.Data2Out, 0);
      check("x0_busy", bus.busyOut, 0);
      we = 1; rd = 7; din = 32'h11111111;
      tick();
      // same-cycle bypass vs. old value
      we = 1; rd = 7; din = 32'hA5A5A5A5; rs1 = 7; rs2 = 7;
      #1 check("byp_d1", bus.Data1Out, 32'hA5A5A5A5);
      check("byp_d2", bus.Data2Out, 32'hA5A5A5A5);
      check("nobyp_d1", bus0.Data1Out, 32'h11111111);
      tick();
      idle();
      // stall on pending x3 and its writeback
      iss = 1; issRd = 3;
      tick();
      idle();
      rs1 = 3; u1 = 1;
      #1 check("stall_x3", {31'b0, bus.stallOut}, 1);
      u1 = 0;
      #1 check("nouse_x3", {31'b0, bus.stallOut}, 0);
      u1 = 1; we = 1; rd = 3; din = 32'h33;
      #1 check("wb_x3", {31'b0, bus.stallOut}, 0);
      check("nb_wb_x3", {31'b0, bus0.stallOut}, 1);
      tick();
      idle();
      rs1 = 3; u1 = 1;
      #1 check("clr_x3", bus.busyOut, 0);
      check("nb_late", {31'b0, bus0.stallOut}, 0);
      tick();
      idle();
      // set wins over clear on the same index
      iss = 1; issRd = 9;
      tick();
      we = 1; rd = 9; din = 32'h99;
      tick();
      idle();
      #1 check("set_wins", bus.busyOut, 32'h0000_0200);
      we = 1; rd = 9; din = 32'h9A;
      tick();
      idle();
      #1 check("clr_x9", bus.busyOut, 0);
      // display port follows only x31
      we = 1; rd = 31; din = 32'h0001ABCD;
      tick();
      idle();
      #1 check("port_x31", {16'b0, bus.portOut}, 32'h0000ABCD);
      we = 1; rd = 30; din = 32'hFFFF5555;
      tick();
      idle();
      rs1 = 30;
      #1 check("port_hold", {16'b0, bus.portOut}, 32'h0000ABCD);
      check("rd_x30", bus.Data1Out, 32'hFFFF5555);
      tick();
      // mixed traffic on a narrow address range to provoke hazards
      for (int i = 0; i < 80; i++) begin
         rs1 = 5'($urandom_range(0, 7));
         rs2 = 5'($urandom_range(0, 7));
         u1 = 1'($urandom);
         u2 = 1'($urandom);
         we = 1'($urandom);
         rd = 5'($urandom_range(0, 7)) | (i % 9 == 0 ? 5'd31 : 5'd0);
         din = $urandom;
         iss = 1'($urandom);
         issRd = 5'($urandom_range(0, 7));
         tick();
      end
      idle();
      tick();
      chk = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end
endmodule
